// File: rtl/dekatron_step_sequencer_if.sv
// rtl/dekatron_step_sequencer_if.sv - control/feedback bundle between digit logic and a dekatron stage
interface dekatron_step_sequencer_if;
  logic       Request;
  logic       Dec;
  logic [3:0] Count;
  logic [9:0] Position;
  logic       Ready;
  logic       Guide1;
  logic       Guide2;
  logic [3:0] PosOut;
  logic       Carry;
  logic       Borrow;
  logic       Done;
  logic       Error;

  modport master (
    output Request, Dec, Count, Position,
    input  Ready, Guide1, Guide2, PosOut, Carry, Borrow, Done, Error
  );

  modport slave (
    input  Request, Dec, Count, Position,
    output Ready, Guide1, Guide2, PosOut, Carry, Borrow, Done, Error
  );
endinterface

// File: rtl/dekatron_step_sequencer.sv
// rtl/dekatron_step_sequencer.sv - guide-pulse step sequencer for one 10-cathode dekatron
// Optional cathode feedback check enabled by macro DEKATRON_POSITION_CHECK_EN.
module dekatron_step_sequencer #(
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input logic Clk,
  input logic Rst,
  dekatron_step_sequencer_if.slave sif
);

  typedef enum logic [2:0] {IDLE, PH_A, PH_B, SETTLE, CHECK, FINISH} state_t;

  localparam logic [7:0] PulseLoad = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GapLoad   = 8'(GAP_CYCLES - 1);

  state_t     state;
  logic [7:0] timer;
  logic [3:0] remaining;
  logic       dirDec;
  logic       ready;
  logic       guide1;
  logic       guide2;
  logic [3:0] posOut;
  logic       carry;
  logic       borrow;
  logic       done;
  logic       error;
  logic [3:0] nextPos;
  logic       mismatch;

  always_comb begin
    nextPos = 4'd0;
    if (dirDec) begin
      nextPos = (posOut == 4'd0) ? 4'd9 : posOut - 4'd1;
    end else begin
      nextPos = (posOut == 4'd9) ? 4'd0 : posOut + 4'd1;
    end
  end

`ifdef DEKATRON_POSITION_CHECK_EN
  logic [9:0] expectedCode;
  assign expectedCode = 10'd1 << nextPos;
  // Exact compare also rejects dark (all-zero) and multi-glow feedback.
  assign mismatch = (sif.Position != expectedCode);
`else
  logic unusedPosition;
  assign unusedPosition = ^sif.Position;
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      timer     <= 8'd0;
      remaining <= 4'd0;
      dirDec    <= 1'b0;
      ready     <= 1'b1;
      guide1    <= 1'b0;
      guide2    <= 1'b0;
      posOut    <= 4'd0;
      carry     <= 1'b0;
      borrow    <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      carry  <= 1'b0;
      borrow <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (sif.Request) begin
            dirDec    <= sif.Dec;
            remaining <= sif.Count;
            error     <= 1'b0;
            ready     <= 1'b0;
            if (sif.Count == 4'd0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else begin
              state  <= PH_A;
              timer  <= PulseLoad;
              guide1 <= ~sif.Dec;
              guide2 <= sif.Dec;
            end
          end
        end
        PH_A: begin
          if (timer == 8'd0) begin
            state  <= PH_B;
            timer  <= PulseLoad;
            guide1 <= dirDec;
            guide2 <= ~dirDec;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        PH_B: begin
          if (timer == 8'd0) begin
            state  <= SETTLE;
            timer  <= GapLoad;
            guide1 <= 1'b0;
            guide2 <= 1'b0;
          end else begin
            timer <= timer - 8'd1;
          end
        end
        SETTLE: begin
          // Wrap pulses are registered here so they coincide with the CHECK cycle.
          if (timer == 8'd0) begin
            state  <= CHECK;
            carry  <= ~dirDec && (posOut == 4'd9);
            borrow <= dirDec && (posOut == 4'd0);
          end else begin
            timer <= timer - 8'd1;
          end
        end
        CHECK: begin
          posOut    <= nextPos;
          remaining <= remaining - 4'd1;
          if (mismatch) begin
            error <= 1'b1;
            state <= FINISH;
            done  <= 1'b1;
          end else if (remaining == 4'd1) begin
            state <= FINISH;
            done  <= 1'b1;
          end else begin
            state  <= PH_A;
            timer  <= PulseLoad;
            guide1 <= ~dirDec;
            guide2 <= dirDec;
          end
        end
        FINISH: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state  <= IDLE;
          ready  <= 1'b1;
          guide1 <= 1'b0;
          guide2 <= 1'b0;
        end
      endcase
    end
  end

  assign sif.Ready  = ready;
  assign sif.Guide1 = guide1;
  assign sif.Guide2 = guide2;
  assign sif.PosOut = posOut;
  assign sif.Carry  = carry;
  assign sif.Borrow = borrow;
  assign sif.Done   = done;
  assign sif.Error  = error;

endmodule
